// File: rtl/pack_qpsk_if.sv
// Symbol-in / word-out handshake bundle for pack_qpsk.
// The master modport is the source/consumer side; the slave modport is the packer.
interface pack_qpsk_if;
   logic        valid_i;
   logic [1:0]  data_i;
   logic        valid_o;
   logic [31:0] data_o;
   logic        ack_i;
   logic        ovf_o;

   modport master (
      output valid_i,
      output data_i,
      output ack_i,
      input  valid_o,
      input  data_o,
      input  ovf_o
   );

   modport slave (
      input  valid_i,
      input  data_i,
      input  ack_i,
      output valid_o,
      output data_o,
      output ovf_o
   );
endinterface

// File: rtl/pack_qpsk.sv
// Packs 16 QPSK dibits LSB-first into a held 32-bit output word with overflow pulse.
// Optional macro PACK_QPSK_RESYNC_EN: any valid_i gap mid-word discards the partial word.
module pack_qpsk (
   input  logic       CLK,
   input  logic       RST,
   pack_qpsk_if.slave bus
);

   typedef enum logic [0:0] {S_IDLE, S_ACTIVE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] sr_q, sr_d;
   logic [31:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        ovf_q, ovf_d;
   logic        complete;
   logic        load;

   // The two oldest bits fall off the end of the shift register.
   logic unused_sr;
   assign unused_sr = ^sr_q[1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ovf_d    = 1'b0;
      complete = 1'b0;
      load     = 1'b0;

      if (bus.valid_i) begin
         sr_d  = {bus.data_i, sr_q[31:2]};
         cnt_d = cnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.valid_i) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (bus.valid_i && cnt_q == 4'd15) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end
`ifdef PACK_QPSK_RESYNC_EN
            else if (!bus.valid_i) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // An ack in the completion cycle frees the slot for the new word.
      load  = complete && (!valid_q || bus.ack_i);
      ovf_d = complete && valid_q && !bus.ack_i;

      if (load) begin
         data_d  = sr_d;
         valid_d = 1'b1;
      end else if (valid_q && bus.ack_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= 32'h0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   // Shift register is intentionally not reset; outputs never see stale contents.
   always_ff @(posedge CLK) begin
      sr_q <= sr_d;
   end

   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_pack_qpsk.sv
// Directed self-checking bench for pack_qpsk; honours PACK_QPSK_RESYNC_EN if defined.
module tb_pack_qpsk;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   pack_qpsk_if bus ();

   pack_qpsk u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One symbol per clock; returns 1 time unit after the accepting edge.
   task automatic send(input logic [1:0] sym, input logic ack);
      bus.valid_i = 1'b1;
      bus.data_i  = sym;
      bus.ack_i   = ack;
      @(posedge CLK);
      #1;
      bus.valid_i = 1'b0;
      bus.ack_i   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic ack_once();
      bus.ack_i = 1'b1;
      @(posedge CLK);
      #1;
      bus.ack_i = 1'b0;
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.data_i  = 2'b00;
      bus.ack_i   = 1'b0;

      idle(2);
      chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
      chk("rst_data", bus.data_o, 32'h0);
      chk("rst_ovf", {31'b0, bus.ovf_o}, 32'h0);
      RST = 1'b0;
      idle(1);

      // Counting pattern 0,1,2,3 repeated -> E4 per byte
      for (int i = 0; i < 15; i++) send(2'(i % 4), 1'b0);
      chk("e4_not_yet", {31'b0, bus.valid_o}, 32'h0);
      send(2'd3, 1'b0);
      chk("e4_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("e4_data", bus.data_o, 32'hE4E4E4E4);
      chk("e4_ovf", {31'b0, bus.ovf_o}, 32'h0);
      idle(2);
      chk("e4_held", {31'b0, bus.valid_o}, 32'h1);

      ack_once();
      chk("ack_valid_low", {31'b0, bus.valid_o}, 32'h0);
      chk("ack_data_held", bus.data_o, 32'hE4E4E4E4);
      idle(1);
      chk("ack_data_held2", bus.data_o, 32'hE4E4E4E4);

      // All-ones, no ack: second word overflows
      for (int i = 0; i < 16; i++) send(2'b11, 1'b0);
      chk("ff_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("ff_data", bus.data_o, 32'hFFFFFFFF);
      for (int i = 0; i < 8; i++) send(2'b00, 1'b0);
      chk("ff_data_not_sr", bus.data_o, 32'hFFFFFFFF);
      for (int i = 0; i < 8; i++) send(2'b11, 1'b0);
      chk("ovf_pulse", {31'b0, bus.ovf_o}, 32'h1);
      chk("ovf_data_kept", bus.data_o, 32'hFFFFFFFF);
      chk("ovf_valid_kept", {31'b0, bus.valid_o}, 32'h1);
      idle(1);
      chk("ovf_one_cycle", {31'b0, bus.ovf_o}, 32'h0);
      ack_once();
      chk("ff_cleared", {31'b0, bus.valid_o}, 32'h0);

      // 01 word then 10 word with ack on the completing cycle
      for (int i = 0; i < 16; i++) send(2'b01, 1'b0);
      chk("w55_data", bus.data_o, 32'h55555555);
      for (int i = 0; i < 8; i++) send(2'b10, 1'b0);
      chk("w55_held", bus.data_o, 32'h55555555);
      for (int i = 0; i < 7; i++) send(2'b10, 1'b0);
      send(2'b10, 1'b1);
      chk("swap_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("swap_data", bus.data_o, 32'hAAAAAAAA);
      chk("swap_ovf", {31'b0, bus.ovf_o}, 32'h0);
      ack_once();
      chk("swap_cleared", {31'b0, bus.valid_o}, 32'h0);

      // Gap mid-word
      for (int i = 0; i < 8; i++) send(2'b11, 1'b0);
      idle(3);
      for (int i = 0; i < 8; i++) send(2'b00, 1'b0);
`ifdef PACK_QPSK_RESYNC_EN
      chk("gap_no_word", {31'b0, bus.valid_o}, 32'h0);
      chk("gap_data_kept", bus.data_o, 32'hAAAAAAAA);
`else
      chk("gap_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("gap_data", bus.data_o, 32'h0000FFFF);
`endif
      chk("gap_ovf", {31'b0, bus.ovf_o}, 32'h0);
      ack_once();
      for (int i = 0; i < 16; i++) send(2'b10, 1'b0);
      chk("fresh_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("fresh_data", bus.data_o, 32'hAAAAAAAA);

      // Reset mid-word with a word still pending
      for (int i = 0; i < 5; i++) send(2'b01, 1'b0);
      RST = 1'b1;
      #2;
      chk("arst_valid", {31'b0, bus.valid_o}, 32'h0);
      chk("arst_data", bus.data_o, 32'h0);
      chk("arst_ovf", {31'b0, bus.ovf_o}, 32'h0);
      RST = 1'b0;
      idle(1);
      for (int i = 0; i < 15; i++) send(2'b10, 1'b0);
      chk("post_rst_not_yet", {31'b0, bus.valid_o}, 32'h0);
      send(2'b10, 1'b0);
      chk("post_rst_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("post_rst_data", bus.data_o, 32'hAAAAAAAA);
      chk("post_rst_ovf", {31'b0, bus.ovf_o}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
